// File: rtl/dm_cache_if.sv
// dm_cache_if: CPU-side and memory-side signals of the direct-mapped cache controller.
interface dm_cache_if #(
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
  localparam int LINE_W = DATA_W * (2 ** OFFSET_W);
  logic              cpu_req, cpu_we, cpu_ready, cpu_done, cpu_hit;
  logic [ADDR_W-1:0] cpu_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata, mem_wdata;
  logic              flush, flush_busy;
  logic              mem_req, mem_we, mem_ack;
  logic [LINE_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
    input  cpu_ready, cpu_done, cpu_hit, cpu_rdata, flush_busy,
           mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ack, mem_rdata,
    output cpu_ready, cpu_done, cpu_hit, cpu_rdata, flush_busy,
           mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-through, no-write-allocate cache with refill, flush engine and hit/miss counters.
module dm_cache_ctrl #(
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input logic      clk,
  input logic      rst,
  dm_cache_if.slave bus
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
  localparam int LINE_W = DATA_W * (2 ** OFFSET_W);
  localparam int ENT_W  = 1 + TAG_W + LINE_W;
  localparam logic [2:0] FLUSH = 3'd0, IDLE = 3'd1, COMPARE = 3'd2, REFILL = 3'd3, WRITE = 3'd4;

  logic [2:0]          state;
  logic [INDEX_W-1:0]  idx;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                we, hit_q, hit, accept;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] off;
  logic [ENT_W-1:0]    ram [2**INDEX_W];
  logic [ENT_W-1:0]    rd;
  logic                ram_we;
  logic [INDEX_W-1:0]  ram_wa;
  logic [ENT_W-1:0]    ram_wd;
  logic [LINE_W-1:0]   patched;

  // Entry layout: {valid, tag, line}
  assign {tag, index, off} = addr;
  assign hit    = rd[ENT_W-1] && rd[LINE_W +: TAG_W] == tag;
  assign accept = state == IDLE && !bus.flush && bus.cpu_req;

  assign bus.cpu_ready  = state == IDLE;
  assign bus.flush_busy = state == FLUSH;
  assign bus.mem_req    = state == REFILL || state == WRITE;
  assign bus.mem_we     = state == WRITE;
  assign bus.mem_addr   = state == WRITE ? addr : state == REFILL ? {tag, index, OFFSET_W'(0)} : '0;
  assign bus.mem_wdata  = state == WRITE ? wdata : '0;

  // A write hit rewrites the line captured at accept with just the addressed word replaced
  always_comb begin
    patched = rd[LINE_W-1:0];
    patched[int'(off)*DATA_W +: DATA_W] = wdata;
    ram_we = state == FLUSH || (bus.mem_ack && (state == REFILL || (state == WRITE && hit_q)));
    ram_wa = state == FLUSH ? idx : index;
    ram_wd = state == FLUSH ? '0 : {1'b1, tag, state == REFILL ? bus.mem_rdata : patched};
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    if (accept) rd <= ram[bus.cpu_addr[OFFSET_W +: INDEX_W]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FLUSH;
      idx           <= '0;
      addr          <= '0;
      wdata         <= '0;
      we            <= 1'b0;
      hit_q         <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_hit   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.hit_cnt   <= '0;
      bus.miss_cnt  <= '0;
    end else begin
      bus.cpu_done <= 1'b0;
      bus.cpu_hit  <= 1'b0;
      case (state)
        FLUSH: begin
          idx <= idx + INDEX_W'(1);
          if (&idx) state <= IDLE;
        end
        IDLE: begin
          if (bus.flush) begin
            state <= FLUSH;
            idx   <= '0;
          end else if (bus.cpu_req) begin
            state <= COMPARE;
            we    <= bus.cpu_we;
            addr  <= bus.cpu_addr;
            wdata <= bus.cpu_wdata;
          end
        end
        COMPARE: begin
          hit_q <= hit;
          if (hit && !(&bus.hit_cnt)) bus.hit_cnt <= bus.hit_cnt + CNT_W'(1);
          if (!hit && !(&bus.miss_cnt)) bus.miss_cnt <= bus.miss_cnt + CNT_W'(1);
          state <= we ? WRITE : hit ? IDLE : REFILL;
          if (!we && hit) begin
            bus.cpu_done  <= 1'b1;
            bus.cpu_hit   <= 1'b1;
            bus.cpu_rdata <= rd[int'(off)*DATA_W +: DATA_W];
          end
        end
        REFILL: if (bus.mem_ack) begin
          state         <= IDLE;
          bus.cpu_done  <= 1'b1;
          bus.cpu_rdata <= bus.mem_rdata[int'(off)*DATA_W +: DATA_W];
        end
        WRITE: if (bus.mem_ack) begin
          state        <= IDLE;
          bus.cpu_done <= 1'b1;
          bus.cpu_hit  <= hit_q;
        end
        default: state <= FLUSH;
      endcase
    end
  end
endmodule
